norflash_arb: RTL and testbench
===============================

NORFLASH_ARB -- requirements
Module: norflash_arb

Interface
REQ-001 Parameter TIMEOUT, default 8'd64: maximum cycles a granted strobe may wait for s_ack_i; used only when NORFLASH_ARB_TIMEOUT_EN is defined.
REQ-002 sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_adr_i, m1_adr_i  input  32  master word/byte address.
REQ-005 m0_dat_i, m1_dat_i  input  32  master write data.
REQ-006 m0_sel_i, m1_sel_i  input  4  master byte selects.
REQ-007 m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i  input  1  master Wishbone controls.
REQ-008 m0_dat_o, m1_dat_o  output  32  read data; both driven from s_dat_i.
REQ-009 m0_ack_o, m1_ack_o  output  1  per-master acknowledge.
REQ-010 m0_err_o, m1_err_o  output  1  per-master error (timeout).
REQ-011 s_adr_o, s_dat_o  output  32  address and write data to the flash controller.
REQ-012 s_sel_o  output  4  byte selects to the flash controller.
REQ-013 s_cyc_o, s_stb_o, s_we_o  output  1  Wishbone controls to the flash controller.
REQ-014 s_dat_i  input  32  read data from the flash controller.
REQ-015 s_ack_i  input  1  acknowledge from the flash controller.

Function
REQ-016 States: IDLE, GNT0, GNT1; grant is registered; every s_* output is muxed from the registered grant.
REQ-017 IDLE: all s_* controls 0; a request is mX_cyc_i=1.
REQ-018 IDLE arbitration: the single requester wins; if both request, the master holding the priority bit wins.
REQ-019 Latency: a request sampled in IDLE at edge N drives s_cyc_o=1 from edge N+1 onward.
REQ-020 GNTx: s_adr_o, s_dat_o, s_sel_o, s_we_o come from master x; s_cyc_o = mx_cyc_i; s_stb_o = mx_cyc_i & mx_stb_i.
REQ-021 GNTx: mx_ack_o = s_ack_i; the other master's ack and err are held at 0.
REQ-022 The grant is held while mx_cyc_i=1, so locked multi-beat cycles are not split.
REQ-023 GNTx exits to IDLE on the edge where mx_cyc_i=0.
REQ-024 On that exit the priority bit passes to the other master (round-robin).
REQ-025 A master that drops cyc and re-asserts it cannot be re-granted without a pass through IDLE (one dead cycle minimum).
REQ-026 s_ack_i received while in IDLE is ignored and never forwarded.
REQ-027 With both masters requesting continuously, grants alternate m0, m1, m0, ...

Reset
REQ-028 While sys_rst_n=0, asynchronously: state=IDLE, priority bit selects m0, timeout counter=0.
REQ-029 Under reset, all ack, err and s_* control outputs are 0; data and address outputs are 0.
REQ-030 Reset mid-transfer drops s_cyc_o and s_stb_o immediately, with no ack or err.
REQ-031 After reset release, arbitration resumes on the first edge.

Configuration
REQ-032 Macro NORFLASH_ARB_TIMEOUT_EN, when defined, adds an 8-bit counter.
REQ-033 The counter increments each cycle with s_stb_o=1 and s_ack_i=0, and clears on s_ack_i or in IDLE.
REQ-034 When the counter reaches TIMEOUT: mx_err_o=1 for one cycle; s_cyc_o and s_stb_o drop in that same cycle; state goes to IDLE; priority rotates.
REQ-035 If s_ack_i arrives in the cycle the counter reaches TIMEOUT, ack wins: no err, counter clears.
REQ-036 Without the macro: no counter, err outputs tied to 0, waits are unbounded.

Verification
REQ-037 m0 single read, s_ack_i after 8 cycles, s_dat_i=32'hDEADBEEF -> s_cyc_o at N+1, m0_ack_o one cycle, m0_dat_o=32'hDEADBEEF, m1_ack_o=0.
REQ-038 m0 and m1 both raise cyc in IDLE after reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then m1 granted.
REQ-039 m1 holds cyc over 3 acked beats while m0 requests -> no switch until m1_cyc_i=0; then m0 granted.
REQ-040 Both masters continuously requesting for 6 transactions -> grant order m0,m1,m0,m1,m0,m1.
REQ-041 Macro defined, TIMEOUT=8'd16, s_ack_i stuck at 0 -> m0_err_o pulses after 16 stalled cycles, s_stb_o drops, state IDLE.
REQ-042 Macro defined, same setup -> m1_err_o never asserts.
REQ-043 sys_rst_n pulsed low mid-write -> s_cyc_o=0 asynchronously, no ack/err, priority back to m0.

Source files
------------

// File: rtl/norflash_arb.sv
// norflash_arb: two-master Wishbone round-robin arbiter in front of a NOR flash controller.
// Optional stall watchdog enabled with `define NORFLASH_ARB_TIMEOUT_EN.
`default_nettype none

module norflash_arb #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m1_dat_o,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;   // 0: m0 wins a tie, 1: m1 wins a tie
  logic   gnt_cyc, gnt_stb;
  logic   tmo_hit;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    gnt_cyc = 1'b0;
    gnt_stb = 1'b0;
    case (state_q)
      GNT0: begin
        gnt_cyc = m0_cyc_i;
        gnt_stb = m0_cyc_i & m0_stb_i;
      end
      GNT1: begin
        gnt_cyc = m1_cyc_i;
        gnt_stb = m1_cyc_i & m1_stb_i;
      end
      default: ;
    endcase
  end

`ifdef NORFLASH_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // An ack landing in the expiry cycle takes precedence over the timeout.
  assign tmo_hit = gnt_cyc & (tmo_cnt_q == TIMEOUT) & ~s_ack_i;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d == IDLE || s_ack_i) begin
      tmo_cnt_d = 8'd0;
    end else if (gnt_stb) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    s_sel_o  = 4'd0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || !prio_q)) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = gnt_cyc & ~tmo_hit;
        s_stb_o  = gnt_stb & ~tmo_hit;
        m0_ack_o = s_ack_i;
        m0_err_o = tmo_hit;
        if (!m0_cyc_i || tmo_hit) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = gnt_cyc & ~tmo_hit;
        s_stb_o  = gnt_stb & ~tmo_hit;
        m1_ack_o = s_ack_i;
        m1_err_o = tmo_hit;
        if (!m1_cyc_i || tmo_hit) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_norflash_arb.sv
// Directed self-checking bench for norflash_arb (arbitration, locking, reset, optional timeout).
`default_nettype none

module tb_norflash_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_cyc, s_stb, s_we, s_ack;

  int passed = 0;
  int total  = 0;

  norflash_arb #(.TIMEOUT(8'd16)) dut (
    .sys_clk  (clk),      .sys_rst_n(rst_n),
    .m0_adr_i (m0_adr),   .m0_dat_i (m0_dat),  .m0_sel_i(m0_sel),
    .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),  .m0_we_i (m0_we),
    .m1_adr_i (m1_adr),   .m1_dat_i (m1_dat),  .m1_sel_i(m1_sel),
    .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),  .m1_we_i (m1_we),
    .m0_dat_o (m0_dat_o), .m1_dat_o (m1_dat_o),
    .m0_ack_o (m0_ack),   .m1_ack_o (m1_ack),
    .m0_err_o (m0_err),   .m1_err_o (m1_err),
    .s_adr_o  (s_adr),    .s_dat_o  (s_dat_o), .s_sel_o (s_sel),
    .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),   .s_we_o  (s_we),
    .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_adr = 32'h0000_0100; m0_dat = 32'hA0A0_A0A0; m0_sel = 4'hF;
    m1_adr = 32'h0000_0200; m1_dat = 32'h1234_5678; m1_sel = 4'h3;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    s_dat_i = 32'd0; s_ack = 1'b0;

    // Reset state
    #3;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_acks",  {m0_ack, m1_ack, m0_err, m1_err}, 0);
    tick(); tick();
    rst_n = 1'b1;

    // m0 single read with a slow ack
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1 chk("t1_idle_cyc", s_cyc, 0);
    tick();
    chk("t1_cyc_n1", s_cyc, 1);
    chk("t1_stb",    s_stb, 1);
    chk("t1_adr",    s_adr, 32'h100);
    chk("t1_sel",    s_sel, 4'hF);
    for (int i = 0; i < 7; i++) begin
      chk("t1_wait_ack", m0_ack, 0);
      tick();
    end
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack",    m0_ack, 1);
    chk("t1_dat",    m0_dat_o, 32'hDEAD_BEEF);
    chk("t1_m1_ack", m1_ack, 0);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t1_ack_once", m0_ack, 0);
    chk("t1_cyc_drop", s_cyc, 0);
    tick();

    // m1 write interrupted by reset; priority must return to m0
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    tick();
    chk("rw_gnt1_adr", s_adr, 32'h200);
    chk("rw_gnt1_dat", s_dat_o, 32'h1234_5678);
    chk("rw_gnt1_we",  s_we, 1);
    #2;
    rst_n = 1'b0; s_ack = 1'b1;
    #1;
    chk("rw_async_cyc", s_cyc, 0);
    chk("rw_async_stb", s_stb, 0);
    chk("rw_no_ackerr", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    chk("rw_adr_zero",  s_adr, 0);
    s_ack = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rw_rst_idle", s_cyc, 0);

    // Both request after reset: m0 first, one IDLE cycle, then m1
    tick();
    chk("both_m0_first", s_adr, 32'h100);
    chk("both_m0_we",    s_we, 0);
    s_ack = 1'b1;
    #1;
    chk("both_ack_m0", {m0_ack, m1_ack}, 2'b10);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("both_dead_cyc", s_cyc, 0);
    s_ack = 1'b1;
    #1;
    chk("idle_ack_ignored", {m0_ack, m1_ack}, 2'b00);
    s_ack = 1'b0;
    tick();
    chk("both_m1_second", s_adr, 32'h200);
    chk("both_m1_cyc",    s_cyc, 1);

    // m1 locked over three beats while m0 waits
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_ack = 1'b1;
      #1;
      chk("lock_m1_ack", {m0_ack, m1_ack}, 2'b01);
      tick();
      s_ack = 1'b0;
      chk("lock_hold", s_adr, 32'h200);
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    tick();
    chk("lock_idle", s_cyc, 0);
    tick();
    chk("lock_m0_gnt", s_adr, 32'h100);

    // Continuous requests from both: grants alternate m0,m1,...
    m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", s_adr, (k % 2 == 0) ? 32'h100 : 32'h200);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      if (k % 2 == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      else            begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      tick();
      chk("rr_idle", s_cyc, 0);
      if (k < 5) begin
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
      end
    end
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
    tick();

    // m0 stalls with no ack from the flash controller
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("stall_stb", s_stb, 1);
      chk("stall_err", {m0_err, m1_err}, 2'b00);
      tick();
    end
`ifdef NORFLASH_ARB_TIMEOUT_EN
    chk("tmo_m0_err", m0_err, 1);
    chk("tmo_m1_err", m1_err, 0);
    chk("tmo_stb",    s_stb, 0);
    chk("tmo_cyc",    s_cyc, 0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("tmo_err_pulse", m0_err, 0);
    chk("tmo_idle",      s_cyc, 0);
`else
    for (int i = 0; i < 8; i++) begin
      chk("nt_stb_held", s_stb, 1);
      chk("nt_no_err",   {m0_err, m1_err}, 2'b00);
      tick();
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("nt_idle", s_cyc, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
